// File: rtl/vec_dispatch_queue_pkg.sv
// Shared vector-dispatch constants: opcode/funct3 encodings, default
// scalar width, FSM state type and classification helpers.
package vec_dispatch_queue_pkg;

    localparam int VEC_XLEN = 32;

    localparam logic [6:0] V_ARITH = 7'h57;
    localparam logic [6:0] V_LOAD  = 7'h07;
    localparam logic [6:0] V_STORE = 7'h27;
    localparam logic [2:0] CONF    = 3'b111;

    typedef enum logic {
        RUN   = 1'b0,
        FENCE = 1'b1
    } dispatch_state_e;

    // True for any opcode handled by the vector unit.
    function automatic logic is_vec_opcode(input logic [6:0] opcode);
        return (opcode == V_ARITH) || (opcode == V_LOAD) || (opcode == V_STORE);
    endfunction

    // vsetvli/vsetivli/vsetvl share the arithmetic opcode with funct3 = 111.
    function automatic logic is_conf_inst(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == V_ARITH) && (funct3 == CONF);
    endfunction

endpackage

// File: rtl/vec_fifo.sv
// First-word-fall-through circular FIFO with synchronous flush.
// The head entry is always visible on rd_data; it is valid while !empty.
module vec_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: storage has no reset; contents are don't-care until written and gated by count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/vec_dispatch_queue.sv
// Scalar-side issue buffer: classifies offered instructions, queues vector
// ones with their operands for vec_decode, and fences on vector config
// instructions until the CSR unit returns vl, which is written back to rd.
module vec_dispatch_queue
    import vec_dispatch_queue_pkg::*;
#(
    parameter int XLEN  = VEC_XLEN,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] inst_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    output logic            inst_ready,
    output logic            is_vec,
    output logic            vec_valid,
    output logic [XLEN-1:0] vec_inst,
    output logic [XLEN-1:0] vec_rs1_data,
    output logic [XLEN-1:0] vec_rs2_data,
    input  logic            vec_ready,
    input  logic            vl_valid,
    input  logic [XLEN-1:0] vl_in,
    output logic            rd_wr_en,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            busy
);

    dispatch_state_e state_q, state_d;
    logic            full;
    logic            empty;
    logic            is_conf;
    logic            push;
    logic            pop;
    logic            conf_push;
    logic [3*XLEN-1:0] head;

    assign is_vec     = is_vec_opcode(inst_in[6:0]);
    assign is_conf    = is_conf_inst(inst_in[6:0], inst_in[14:12]);
    assign inst_ready = (state_q == RUN) && !full;
    assign push       = inst_valid && inst_ready && is_vec && !flush;
    assign pop        = vec_valid && vec_ready && !flush;
    assign conf_push  = push && is_conf;

    vec_fifo #(
        .WIDTH (3*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .wr_data ({inst_in, rs1_in, rs2_in}),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign vec_valid    = !empty;
    assign vec_inst     = head[3*XLEN-1:2*XLEN];
    assign vec_rs1_data = head[2*XLEN-1:XLEN];
    assign vec_rs2_data = head[XLEN-1:0];
    assign busy         = vec_valid || (state_q == FENCE);

    // Dispatch state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next-state logic: fence on config enqueue, release on vl or flush.
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (conf_push) state_d = FENCE;
            FENCE:   if (flush || vl_valid) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Capture the fence destination and emit the one-cycle vl writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_wr_en <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            rd_wr_en <= 1'b0;
            if (conf_push) rd_addr <= inst_in[11:7];
            if (!flush && (state_q == FENCE) && vl_valid && (rd_addr != 5'd0)) begin
                rd_wr_en <= 1'b1;
                rd_data  <= vl_in;
            end
        end
    end

endmodule

// File: tb/tb_vec_dispatch_queue.sv
// Self-checking bench for vec_dispatch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_vec_dispatch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic            inst_valid = 1'b0;
    logic [XLEN-1:0] inst_in = '0;
    logic [XLEN-1:0] rs1_in = '0;
    logic [XLEN-1:0] rs2_in = '0;
    logic            vec_ready = 1'b0;
    logic            vl_valid = 1'b0;
    logic [XLEN-1:0] vl_in = '0;

    logic            inst_ready;
    logic            is_vec;
    logic            vec_valid;
    logic [XLEN-1:0] vec_inst;
    logic [XLEN-1:0] vec_rs1_data;
    logic [XLEN-1:0] vec_rs2_data;
    logic            rd_wr_en;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            busy;

    vec_dispatch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .inst_valid   (inst_valid),
        .inst_in      (inst_in),
        .rs1_in       (rs1_in),
        .rs2_in       (rs2_in),
        .inst_ready   (inst_ready),
        .is_vec       (is_vec),
        .vec_valid    (vec_valid),
        .vec_inst     (vec_inst),
        .vec_rs1_data (vec_rs1_data),
        .vec_rs2_data (vec_rs2_data),
        .vec_ready    (vec_ready),
        .vl_valid     (vl_valid),
        .vl_in        (vl_in),
        .rd_wr_en     (rd_wr_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of accepted vector instructions plus fence state.
    typedef struct {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } entry_t;

    entry_t          q[$];
    bit              m_fence;
    logic [4:0]      m_rd;
    logic            m_wr;
    logic [XLEN-1:0] m_data;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_is_vec(input logic [XLEN-1:0] i);
        return i[6:0] == 7'h57 || i[6:0] == 7'h07 || i[6:0] == 7'h27;
    endfunction

    function automatic bit model_is_conf(input logic [XLEN-1:0] i);
        return i[6:0] == 7'h57 && i[14:12] == 3'b111;
    endfunction

    task automatic model_reset();
        q.delete();
        m_fence = 1'b0;
        m_rd    = '0;
        m_wr    = 1'b0;
        m_data  = '0;
    endtask

    task automatic compare_outputs();
        bit exp_ready;
        exp_ready = !m_fence && (q.size() < DEPTH);
        check("inst_ready", inst_ready, exp_ready);
        check("is_vec", is_vec, model_is_vec(inst_in));
        check("vec_valid", vec_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("vec_inst", vec_inst, q[0].inst);
            check("vec_rs1", vec_rs1_data, q[0].rs1);
            check("vec_rs2", vec_rs2_data, q[0].rs2);
        end
        check("busy", busy, (q.size() != 0) || m_fence);
        check("rd_wr_en", rd_wr_en, m_wr);
        check("rd_addr", rd_addr, m_rd);
        check("rd_data", rd_data, m_data);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit accept;
        entry_t e;
        if (flush) begin
            q.delete();
            m_fence = 1'b0;
            m_wr    = 1'b0;
        end else begin
            accept = inst_valid && !m_fence && (q.size() < DEPTH) && model_is_vec(inst_in);
            m_wr = 1'b0;
            if (m_fence && vl_valid) begin
                m_fence = 1'b0;
                if (m_rd != 5'd0) begin
                    m_wr   = 1'b1;
                    m_data = vl_in;
                end
            end
            if (q.size() != 0 && vec_ready) void'(q.pop_front());
            if (accept) begin
                e.inst = inst_in;
                e.rs1  = rs1_in;
                e.rs2  = rs2_in;
                q.push_back(e);
                if (model_is_conf(inst_in)) begin
                    m_fence = 1'b1;
                    m_rd    = inst_in[11:7];
                end
            end
        end
    endtask

    task automatic cycle(input logic iv, input logic [XLEN-1:0] inst, input logic [XLEN-1:0] r1,
                         input logic [XLEN-1:0] r2, input logic vr, input logic vlv,
                         input logic [XLEN-1:0] vl, input logic fl);
        @(negedge clk);
        inst_valid = iv;
        inst_in    = inst;
        rs1_in     = r1;
        rs2_in     = r2;
        vec_ready  = vr;
        vl_valid   = vlv;
        vl_in      = vl;
        flush      = fl;
        #2;
        compare_outputs();
        model_step();
    endtask

    task automatic idle(input logic vr);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, vr, 1'b0, 32'h0, 1'b0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset      = 1'b0;
        inst_valid = 1'b0;
        vec_ready  = 1'b0;
        vl_valid   = 1'b0;
        flush      = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [XLEN-1:0] rand_inst();
        logic [XLEN-1:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    w[6:0] = 7'h57;
            2: begin
                w[6:0]   = 7'h57;
                w[14:12] = 3'b111;
            end
            3:       w[6:0] = 7'h07;
            4:       w[6:0] = 7'h27;
            5, 6:    w[6:0] = 7'h13;
            default: w[6:0] = 7'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        model_reset();
        do_reset();

        // Single vadd.vv: visible one cycle after push, then consumed.
        cycle(1'b1, 32'h0220_8057, 32'd5, 32'd7, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to DEPTH with vector loads, then offer more while full, then pop+push.
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b1, 32'h0000_0007 | (32'(i + 1) << 7), 32'(100 + i), 32'(200 + i), 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 32'h0000_0027 | (32'(i + 10) << 7), 32'(300 + i), 32'(400 + i), 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // Scalar addi: accepted and dropped.
        cycle(1'b1, 32'h0050_0093, 32'd1, 32'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1'b0);

        // vsetvli x5 with vl returned three cycles later.
        cycle(1'b1, 32'h0C05_72D7, 32'd8, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h0220_8057, 32'd9, 32'd9, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd16, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // vsetvli x0: no writeback strobe; stray vl_valid in RUN ignored.
        cycle(1'b1, 32'h0C05_7057, 32'd3, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd32, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd64, 1'b0);
        idle(1'b0);

        // Two entries plus a fence, then flush together with vl_valid.
        cycle(1'b1, 32'h0220_8057, 32'd11, 32'd12, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0007, 32'd13, 32'd14, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0C05_72D7, 32'd15, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
        cycle(1'b1, 32'h0000_0027, 32'd1, 32'd1, 1'b1, 1'b1, 32'd77, 1'b1);
        idle(1'b0);

        // Reset in the middle of a fence.
        cycle(1'b1, 32'h0220_8057, 32'd21, 32'd22, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0C05_7357, 32'd23, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 15, $urandom,
                  $urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_dispatch_queue.md
# vec_dispatch_queue

Scalar-side issue buffer between the scalar pipeline and `vec_decode`. It classifies each instruction offered by the scalar core as vector or non-vector. Vector instructions are buffered together with their rs1/rs2 operands in a small FIFO and presented to `vec_decode` through a valid/ready handshake. For configuration instructions (vsetvli/vsetivli/vsetvl), it blocks further issue until the CSR unit returns the new `vl`, then writes that value back to scalar `rd`.

## Interface
Parameters:
- `XLEN`, 32, scalar/instruction width
- `DEPTH`, 4, FIFO entries; power of two, at least 2

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous; empties the queue and cancels a pending fence
- `inst_valid`  in  1  scalar core offers an instruction
- `inst_in`  in  XLEN  instruction word
- `rs1_in`, `rs2_in`  in  XLEN  scalar operand values
- `inst_ready`  out  1  offer accepted this cycle
- `is_vec`  out  1  combinational: `inst_in` is a vector opcode
- `vec_valid`  out  1  head entry is valid
- `vec_inst`, `vec_rs1_data`, `vec_rs2_data`  out  XLEN  head entry, fed to `vec_decode`
- `vec_ready`  in  1  vector side consumes the head
- `vl_valid`  in  1  CSR unit has committed a new `vl` (single-cycle pulse)
- `vl_in`  in  XLEN  new `vl` value
- `rd_wr_en`  out  1  one-cycle scalar writeback strobe
- `rd_addr`  out  5  writeback register
- `rd_data`  out  XLEN  writeback value (`vl`)
- `busy`  out  1  queue non-empty or fence pending

## Operation
- Classification: `is_vec` = opcode `inst_in[6:0]` ∈ {0x57 V_ARITH, 0x07 V_LOAD, 0x27 V_STORE}.
- Config instruction: opcode 0x57 and funct3 = 3'b111.
- FSM has two states:
  - RUN → FENCE when a config instruction is enqueued.
  - FENCE → RUN on `vl_valid`, or on `flush`.
- `inst_ready` = (state == RUN) && !full, regardless of `is_vec`.
- Enqueue when `inst_valid && inst_ready && is_vec`.
- When `inst_valid && inst_ready && !is_vec`, the instruction is accepted and dropped. Nothing is queued.
- FIFO:
  - Circular buffer of {inst, rs1, rs2}.
  - `wr_ptr`/`rd_ptr` are log2(DEPTH) bits and wrap naturally.
  - `count` is log2(DEPTH)+1 bits.
  - The head is shown first-word-fall-through: `vec_valid` = (count != 0).
- Dequeue on `vec_valid && vec_ready`.
- Push and pop in the same cycle: `count` unchanged, both pointers advance.
- Push into a full queue is impossible because `inst_ready` = 0.
- Fence:
  - On enqueueing a config instruction, capture `rd_addr` = `inst_in[11:7]`.
  - On `vl_valid` in FENCE, register `rd_data` = `vl_in` and pulse `rd_wr_en` for one cycle, only if captured rd != 0.
  - Then return to RUN.
  - `vl_valid` in RUN is ignored: no writeback.
- `flush`:
  - Pointers and count go to 0, state goes to RUN, and any in-flight writeback is cancelled.
  - Takes priority over a simultaneous push, pop, or `vl_valid`.
  - `inst_ready` still evaluates normally that cycle, but no enqueue happens.

## Timing
- Reset values: pointers, count = 0; state = RUN; `vec_valid` = 0; `rd_wr_en` = 0; `rd_addr` = 0; `rd_data` = 0; `busy` = 0.
- `vec_inst`/`vec_rs1_data`/`vec_rs2_data` read the head entry and are don't-care while `vec_valid` = 0. Storage is not reset.
- Latency from accepted push to `vec_valid` is 1 cycle when the queue was empty.
- `inst_ready` drops the cycle after the config enqueue. It stays low until the cycle after `vl_valid`.
- `rd_wr_en` asserts the cycle after `vl_valid`. `inst_ready` may be high in that same cycle.
- Reset mid-fence returns immediately to RUN and drops the writeback.
- The head entry and `vec_valid` stay stable while `vec_ready` = 0.

## Structure
- Opcode/funct3 constants (`V_ARITH`, `V_LOAD`, `V_STORE`, `CONF`) and `XLEN` come from the existing shared defines/package. The FSM state enum `dispatch_state_e` is added there.
- One sub-module is natural: `vec_fifo` (parameterised width/depth, FWFT, count/full/empty). The FSM, classifier and writeback live in the top.

## Test plan
- Reset, then push vadd.vv (0x02208057) with rs1=5, rs2=7 → next cycle `vec_valid`=1, `vec_inst`=0x02208057, `vec_rs1_data`=5; `vec_ready`=1 → count 0.
- Push 4 vector instructions with `vec_ready`=0 → `inst_ready`=0 after the 4th. Then simultaneous pop and push → count stays 4, order preserved across pointer wrap.
- Offer scalar addi (0x00500093) → `inst_ready`=1, `is_vec`=0, `vec_valid` stays 0.
- Push vsetvli x5 (0x0C0572D7), then 3 cycles later `vl_valid`=1, `vl_in`=16 → `inst_ready`=0 throughout the wait. Next cycle `rd_wr_en`=1, `rd_addr`=5, `rd_data`=16; back to RUN.
- vsetvli with rd=x0, then `vl_valid` → no `rd_wr_en` pulse, state returns to RUN.
- Fill 2 entries, enter FENCE, assert `flush` together with `vl_valid` → count 0, `vec_valid`=0, no `rd_wr_en`, `inst_ready`=1 next cycle. Assert `reset` low mid-operation → all outputs at their reset values immediately.
